// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters and a
// saturating mispredict counter; lookup is combinational, update on the clock edge.
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCF,
  output logic                  PredTakenF,
  output logic [ADDR_WIDTH-1:0] PredTargetF,
  input  logic                  UpdateE,
  input  logic [ADDR_WIDTH-1:0] PCE,
  input  logic                  TakenE,
  input  logic [ADDR_WIDTH-1:0] TargetE,
  input  logic                  PredTakenE,
  input  logic [ADDR_WIDTH-1:0] PredTargetE,
  output logic                  MispredictE,
  output logic [CNT_WIDTH-1:0]  MispredictCount
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [ENTRIES-1:0]                 valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]            ctr_q, ctr_d;
  logic [ENTRIES-1:0][TAG_W-1:0]      tag_q, tag_d;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] target_q, target_d;
  logic [CNT_WIDTH-1:0]               count_q, count_d;

  logic [IDX-1:0]   idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;

  // Instruction-alignment bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX+1:2];
  assign tag_f = PCF[ADDR_WIDTH-1:IDX+2];
  assign idx_e = PCE[IDX+1:2];
  assign tag_e = PCE[ADDR_WIDTH-1:IDX+2];

  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    PredTakenF  = hit_f && ctr_q[idx_f][1];
    PredTargetF = PredTakenF ? target_q[idx_f] : PCF + PC_STEP;
    MispredictE = UpdateE &&
                  ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)));
  end

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    count_d  = count_q;
    if (MispredictE && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
    if (UpdateE) begin
      if (hit_e) begin
        if (TakenE) begin
          if (ctr_q[idx_e] != 2'b11) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
          target_d[idx_e] = TargetE;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
        end
      end else if (TakenE) begin
        // Allocation replaces whatever branch currently aliases this slot.
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = TargetE;
        ctr_d[idx_e]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'b01}};
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      count_q <= count_d;
    end
  end

  // Tags and targets need no reset since cleared valid bits mask them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  assign MispredictCount = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-based model of the BTB checked every
// cycle, plus hand-computed literal expectations at the key points.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = '0;
  logic        UpdateE = 1'b0;
  logic [31:0] PCE = '0;
  logic        TakenE = 1'b0;
  logic [31:0] TargetE = '0;
  logic        PredTakenE = 1'b0;
  logic [31:0] PredTargetE = '0;

  logic        PredTakenF, PredTakenF2, MispredictE, MispredictE2;
  logic [31:0] PredTargetF, PredTargetF2;
  logic [31:0] MispredictCount;
  logic [1:0]  MispredictCount2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .MispredictCount(MispredictCount)
  );

  branch_predictor #(.ADDR_WIDTH(32), .ENTRIES(16), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF2), .PredTargetF(PredTargetF2),
    .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE2), .MispredictCount(MispredictCount2)
  );

  // Model: one slot per (pc/4) mod 16, tag is pc/64, direction strength 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_target[16];
  int          m_strength[16];
  longint      m_count32, m_count2;
  bit          model_ready = 1'b0;

  function automatic void predict(input logic [31:0] pc, output logic taken,
                                  output logic [31:0] target);
    int slot;
    slot   = int'((pc / 4) % 16);
    taken  = m_valid[slot] && (m_tag[slot] == pc / 64) && (m_strength[slot] >= 2);
    target = taken ? m_target[slot] : pc + 32'd4;
  endfunction

  function automatic logic wrong_guess();
    return UpdateE && ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic upd, input logic [31:0] pce, input logic taken,
                               input logic [31:0] target, input logic ptaken,
                               input logic [31:0] ptarget);
    @(posedge clk);
    #1;
    UpdateE = upd; PCE = pce; TakenE = taken; TargetE = target;
    PredTakenE = ptaken; PredTargetE = ptarget;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_strength[i] = 1;
      end
      m_count32 = 0;
      m_count2 = 0;
      model_ready = 1'b1;
    end else if (model_ready && UpdateE) begin
      int slot;
      bit hit;
      slot = int'((PCE / 4) % 16);
      hit  = m_valid[slot] && (m_tag[slot] == PCE / 64);
      if (wrong_guess()) begin
        if (m_count32 < 64'h0000_0000_FFFF_FFFF) m_count32++;
        if (m_count2 < 3) m_count2++;
      end
      if (hit) begin
        if (TakenE) begin
          if (m_strength[slot] < 3) m_strength[slot]++;
          m_target[slot] = TargetE;
        end else if (m_strength[slot] > 0) begin
          m_strength[slot]--;
        end
      end else if (TakenE) begin
        m_valid[slot] = 1'b1;
        m_tag[slot] = PCE / 64;
        m_target[slot] = TargetE;
        m_strength[slot] = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      logic        exp_taken;
      logic [31:0] exp_target;
      predict(PCF, exp_taken, exp_target);
      checkOutput("PredTakenF", {31'b0, PredTakenF}, {31'b0, exp_taken});
      checkOutput("PredTargetF", PredTargetF, exp_target);
      checkOutput("MispredictE", {31'b0, MispredictE}, {31'b0, wrong_guess()});
      checkOutput("MispredictCount", MispredictCount, 32'(m_count32));
      checkOutput("PredTakenF_small", {31'b0, PredTakenF2}, {31'b0, exp_taken});
      checkOutput("MispredictCount_small", {30'b0, MispredictCount2}, 32'(m_count2));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    PCF = 32'h100;
    #1;
    checkOutput("reset_taken", {31'b0, PredTakenF}, 32'd0);
    checkOutput("reset_target", PredTargetF, 32'h104);
    checkOutput("reset_count", MispredictCount, 32'd0);

    applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    checkOutput("alloc_mispredict", {31'b0, MispredictE}, 32'd1);
    idle();
    #1;
    checkOutput("alloc_taken", {31'b0, PredTakenF}, 32'd1);
    checkOutput("alloc_target", PredTargetF, 32'h80);
    checkOutput("alloc_count", MispredictCount, 32'd1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    idle();
    #1;
    checkOutput("weak_taken_holds", {31'b0, PredTakenF}, 32'd1);
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    idle();
    #1;
    checkOutput("weak_not_taken", {31'b0, PredTakenF}, 32'd0);
    checkOutput("weak_not_taken_target", PredTargetF, 32'h104);
    checkOutput("count_after_two_nt", MispredictCount, 32'd3);

    applyStimulus(1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    idle();
    #1;
    checkOutput("alias_evicted", PredTargetF, 32'h104);
    PCF = 32'h140;
    #1;
    checkOutput("alias_new_target", PredTargetF, 32'h200);

    PCF = 32'h300;
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
    #1;
    checkOutput("same_cycle_old", PredTargetF, 32'h304);
    idle();
    #1;
    checkOutput("same_cycle_new", PredTargetF, 32'h400);

    applyStimulus(1'b1, 32'h504, 1'b0, 32'h0, 1'b0, 32'h508);
    #1;
    checkOutput("nt_miss_no_mispredict", {31'b0, MispredictE}, 32'd0);
    PCF = 32'h504;
    idle();
    #1;
    checkOutput("nt_miss_no_alloc", PredTargetF, 32'h508);

    PCF = 32'h300;
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h404, 1'b1, 32'h400);
    #1;
    checkOutput("target_mispredict", {31'b0, MispredictE}, 32'd1);
    idle();
    #1;
    checkOutput("target_retrained", PredTargetF, 32'h404);
    checkOutput("count_target_mp", MispredictCount, 32'd6);

    applyStimulus(1'b0, 32'h300, 1'b1, 32'h999, 1'b0, 32'h0);
    #1;
    checkOutput("no_update_no_mp", {31'b0, MispredictE}, 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h304);
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h404, 1'b0, 32'h304);
    idle();
    #1;
    checkOutput("floor_then_taken", {31'b0, PredTakenF}, 32'd0);

    PCF = 32'hFFFF_FFFC;
    #1;
    checkOutput("pc_wrap", PredTargetF, 32'h0);

    rst = 1'b1;
    applyStimulus(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 32'h604);
    @(posedge clk);
    #1;
    rst = 1'b0;
    UpdateE = 1'b0;
    PCF = 32'h600;
    #1;
    checkOutput("reset_blocks_alloc", PredTargetF, 32'h604);
    checkOutput("reset_clears_count", MispredictCount, 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 32'h704);
    idle();
    #1;
    checkOutput("count32_four", MispredictCount, 32'd4);
    checkOutput("count2_saturates", {30'b0, MispredictCount2}, 32'd3);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
